// File: rtl/key_direction.sv
// key_direction: input stage for the snake game. Each raw push-button is
// synchronised, debounced and edge-detected; accepted turns are buffered in
// a two-entry queue and released into dir one per game tick.
module key_direction #(
   parameter int DEBOUNCE_CNT = 200,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       step,
   input  logic       game_over,
   output logic [1:0] dir,
   output logic       moving,
   output logic       key_pulse,
   output logic       key_drop,
   output logic [1:0] queue_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   // Key vector indexed by direction code: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
   logic [3:0]            raw_s;
   logic [3:0]            sync1_q;
   logic [3:0]            sync2_q;
   logic [3:0]            stable_q;
   logic [3:0]            stable_d;
   logic [3:0]            stable_dly_q;
   logic [3:0][CNT_W-1:0] cnt_q;
   logic [3:0][CNT_W-1:0] cnt_d;
   logic [3:0]            press_s;
   logic                  press_any_s;
   logic [1:0]            win_s;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] dir_q;
   logic [1:0] dir_d;
   logic [1:0] head_q;
   logic [1:0] head_d;
   logic [1:0] tail_q;
   logic [1:0] tail_d;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       moving_q;
   logic       moving_d;
   logic       pulse_q;
   logic       pulse_d;
   logic       drop_q;
   logic       drop_d;
   logic [1:0] ref_s;
   logic       pop_s;
   logic       legal_s;
   logic       accept_s;

   assign raw_s       = {key_right, key_left, key_down, key_up};
   assign press_s     = stable_q & ~stable_dly_q;
   assign press_any_s = |press_s;

   assign dir         = dir_q;
   assign moving      = moving_q;
   assign key_pulse   = pulse_q;
   assign key_drop    = drop_q;
   assign queue_count = count_q;

   // Debounce: count consecutive cycles the synchronised key disagrees with its stable value.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = ~stable_q[i];
            cnt_d[i]    = CNT_ZERO;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Synchroniser, debounce and edge-detect registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 4'b0000;
         sync2_q      <= 4'b0000;
         stable_q     <= 4'b0000;
         stable_dly_q <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else begin
         sync1_q      <= raw_s;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
      end
   end

   // Fixed-priority pick among simultaneous presses: UP > DOWN > LEFT > RIGHT.
   always_comb begin
      if (press_s[0]) begin
         win_s = 2'b00;
      end else if (press_s[1]) begin
         win_s = 2'b01;
      end else if (press_s[2]) begin
         win_s = 2'b10;
      end else begin
         win_s = 2'b11;
      end
   end

   // Reference direction for reversal/duplicate checks: newest queued turn, else dir.
   always_comb begin
      case (count_q)
         2'd2:    ref_s = tail_q;
         2'd1:    ref_s = head_q;
         default: ref_s = dir_q;
      endcase
   end

   assign pop_s    = step & (count_q != 2'd0);
   assign legal_s  = (win_s != ref_s) & (win_s != (ref_s ^ 2'b01));
   assign accept_s = press_any_s & legal_s & ((count_q != 2'd2) | pop_s);

   // Game-state FSM: next state, direction and turn-queue update.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      moving_d = moving_q;
      pulse_d  = 1'b0;
      drop_d   = 1'b0;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            if (game_over) begin
               state_d  = ST_OVER;
               moving_d = 1'b0;
               count_d  = 2'd0;
            end else if (press_any_s) begin
               state_d  = ST_RUN;
               dir_d    = win_s;
               moving_d = 1'b1;
               pulse_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (game_over) begin
               state_d  = ST_OVER;
               moving_d = 1'b0;
               count_d  = 2'd0;
            end else begin
               pulse_d = accept_s;
               drop_d  = press_any_s & ~accept_s;
               if (pop_s) begin
                  dir_d = head_q;
               end else begin
                  dir_d = dir_q;
               end
               if (pop_s && accept_s) begin
                  // Occupancy is unchanged; the new turn lands behind what remains.
                  if (count_q == 2'd2) begin
                     head_d = tail_q;
                     tail_d = win_s;
                  end else begin
                     head_d = win_s;
                  end
               end else if (pop_s) begin
                  head_d  = tail_q;
                  count_d = count_q - 2'd1;
               end else if (accept_s) begin
                  if (count_q == 2'd0) begin
                     head_d = win_s;
                  end else begin
                     tail_d = win_s;
                  end
                  count_d = count_q + 2'd1;
               end else begin
                  count_d = count_q;
               end
            end
         end
         ST_OVER: begin
            // Terminal until reset; keys, ticks and game_over are ignored.
            state_d  = ST_OVER;
            moving_d = 1'b0;
            count_d  = 2'd0;
         end
         default: begin
            state_d  = ST_OVER;
            moving_d = 1'b0;
            count_d  = 2'd0;
         end
      endcase
   end

   // Game-state registers; all outputs come straight from these flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dir_q    <= 2'b11;
         moving_q <= 1'b0;
         pulse_q  <= 1'b0;
         drop_q   <= 1'b0;
         head_q   <= 2'b00;
         tail_q   <= 2'b00;
         count_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         moving_q <= moving_d;
         pulse_q  <= pulse_d;
         drop_q   <= drop_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_key_direction.sv
// Testbench for key_direction: directed and random key/tick stimulus, a
// behavioural model that predicts every output cycle, and a scoreboard
// monitor that compares the DUT against those predictions.
module tb_key_direction;

   localparam int DC   = 4;
   localparam int MAXC = 20000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic       step = 1'b0;
   logic       game_over = 1'b0;
   logic [1:0] dir;
   logic       moving, key_pulse, key_drop;
   logic [1:0] queue_count;

   key_direction #(.DEBOUNCE_CNT(DC), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .step(step), .game_over(game_over),
      .dir(dir), .moving(moving), .key_pulse(key_pulse), .key_drop(key_drop),
      .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] dir;
      logic       moving;
      logic       pulse;
      logic       drop;
      logic [1:0] qc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pulse = 0;

   // Reference model state: raw samples and stable key values per edge index.
   bit       raw_h [4][MAXC];
   bit       stab_h[4][MAXC];
   int       cyc = 0;
   int       m_mode = 0;            // 0 idle, 1 running, 2 game over
   bit [1:0] m_dir = 2'b11;
   bit       m_moving = 1'b0;
   bit [1:0] turns[$];

   function automatic bit hr(int i, int k);
      return (k < 0) ? 1'b0 : raw_h[i][k];
   endfunction

   function automatic bit hs(int i, int k);
      return (k < 0) ? 1'b0 : stab_h[i][k];
   endfunction

   // Predict the outputs produced by the clock edge that has just happened.
   task automatic model_edge();
      bit [3:0] rawv;
      bit [3:0] press;
      bit       pulse, drop, all_diff, ev_valid, do_pop;
      bit [1:0] ev, refd;
      int       k;
      exp_t     e;
      k     = cyc;
      rawv  = {key_right, key_left, key_down, key_up};
      pulse = 1'b0;
      drop  = 1'b0;
      if (k >= MAXC) begin
         $display("FAIL cycle_budget model ran past %0d cycles", MAXC);
         $fatal(1, "cycle budget exceeded");
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            raw_h[i][k]  = 1'b0;
            if (k > 0) raw_h[i][k-1] = 1'b0;
            stab_h[i][k] = 1'b0;
         end
         m_mode = 0; m_dir = 2'b11; m_moving = 1'b0;
         turns.delete();
      end else begin
         for (int i = 0; i < 4; i++) begin
            raw_h[i][k] = rawv[i];
            press[i]    = hs(i, k-1) && !hs(i, k-2);
            // Stable value flips once DC consecutive synchronised samples disagree with it.
            all_diff = 1'b1;
            for (int j = 2; j <= DC + 1; j++) begin
               if (k - j < 0 || hr(i, k-j) == hs(i, k-1)) all_diff = 1'b0;
            end
            stab_h[i][k] = all_diff ? !hs(i, k-1) : hs(i, k-1);
         end
         ev_valid = |press;
         ev = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
         if (m_mode == 2) begin
            m_moving = 1'b0;
         end else if (game_over) begin
            m_mode = 2; m_moving = 1'b0;
            turns.delete();
         end else if (m_mode == 0) begin
            if (ev_valid) begin
               m_dir = ev; m_moving = 1'b1; pulse = 1'b1; m_mode = 1;
            end
         end else begin
            refd   = (turns.size() > 0) ? turns[$] : m_dir;
            do_pop = step && (turns.size() > 0);
            if (do_pop) m_dir = turns.pop_front();
            if (ev_valid) begin
               if (ev == refd || ev == (refd ^ 2'b01)) drop = 1'b1;
               else if (turns.size() >= 2)             drop = 1'b1;
               else begin
                  turns.push_back(ev);
                  pulse = 1'b1;
               end
            end
         end
      end
      e.dir = m_dir; e.moving = m_moving; e.pulse = pulse; e.drop = drop;
      e.qc  = 2'(turns.size());
      exp_q.push_back(e);
      cyc++;
   endtask

   // Scoreboard monitor: one prediction per edge, compared mid-cycle.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dir, moving, key_pulse, key_drop, queue_count};
            n_tests++;
            if (key_pulse === 1'b1) n_pulse++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t got dir=%0d mv=%0d kp=%0d kd=%0d qc=%0d expected dir=%0d mv=%0d kp=%0d kd=%0d qc=%0d",
                        $time, a.dir, a.moving, a.pulse, a.drop, a.qc,
                        e.dir, e.moving, e.pulse, e.drop, e.qc);
            end
         end
      end
   end

   // Drive one cycle of inputs, then model the edge that samples them.
   task automatic cyc_in(bit [3:0] keys, bit st, bit go, bit r);
      @(negedge clk);
      {key_right, key_left, key_down, key_up} = keys;
      step = st; game_over = go; rst = r;
      @(posedge clk);
      model_edge();
   endtask

   task automatic hold(bit [3:0] keys, int n, bit st, bit go);
      for (int j = 0; j < n; j++) cyc_in(keys, st && (j == n - 1), go, 1'b0);
   endtask

   initial begin
      #(MAXC * 10 + 1000);
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      // Bounce on UP: short glitch ignored, steady press accepted once.
      repeat (3) cyc_in(4'b0000, 1'b0, 1'b0, 1'b1);
      p0 = n_pulse;
      hold(4'b0001, 3, 1'b0, 1'b0);
      hold(4'b0000, 2, 1'b0, 1'b0);
      hold(4'b0001, 12, 1'b0, 1'b0);
      hold(4'b0000, 8, 1'b0, 1'b0);
      n_tests++;
      if (n_pulse - p0 != 1) begin
         n_fail++;
         $display("FAIL bounce_pulses got %0d expected 1", n_pulse - p0);
      end
      // Simultaneous UP+RIGHT in idle, then queue fill, overflow, pop/push and game over.
      repeat (2) cyc_in(4'b0000, 1'b0, 1'b0, 1'b1);
      hold(4'b1001, 8, 1'b0, 1'b0); hold(4'b0000, 8, 1'b0, 1'b0);
      hold(4'b0001, 8, 1'b0, 1'b0); hold(4'b0000, 8, 1'b0, 1'b0);   // duplicate UP dropped
      hold(4'b0100, 8, 1'b0, 1'b0); hold(4'b0000, 8, 1'b0, 1'b0);   // LEFT queued
      hold(4'b0010, 8, 1'b0, 1'b0); hold(4'b0000, 8, 1'b0, 1'b0);   // DOWN queued
      hold(4'b0001, 8, 1'b0, 1'b0); hold(4'b0000, 8, 1'b0, 1'b0);   // UP dropped (full)
      hold(4'b0000, 3, 1'b1, 1'b0);                                 // pop one
      hold(4'b1000, 6, 1'b0, 1'b0);                                 // RIGHT arrives
      hold(4'b1000, 1, 1'b1, 1'b0);                                 // step around the press
      hold(4'b0000, 8, 1'b0, 1'b0);
      hold(4'b0100, 6, 1'b0, 1'b1); hold(4'b0000, 8, 1'b1, 1'b0);   // game over, then ignored
      // Random episodes with varying tick rates, glitches and occasional resets.
      for (int ep = 0; ep < 16; ep++) begin
         int  sp;
         bit  go;
         int  c;
         sp = $urandom_range(3, 40);
         go = 1'b0;
         c  = 0;
         repeat (2) cyc_in(4'b0000, 1'b0, 1'b0, 1'b1);
         while (c < 450) begin
            bit [3:0] k;
            int       n, r;
            r = $urandom_range(0, 99);
            if (r < 45) begin
               k = 4'b0000; n = $urandom_range(DC + 1, 3 * DC);
            end else if (r < 80) begin
               k = 4'b0001 << $urandom_range(0, 3); n = $urandom_range(DC + 1, 3 * DC);
            end else if (r < 92) begin
               k = 4'($urandom_range(1, 15)); n = $urandom_range(DC + 1, 3 * DC);
            end else begin
               k = 4'b0001 << $urandom_range(0, 3); n = $urandom_range(1, DC);
            end
            for (int j = 0; j < n; j++) begin
               if (c > 350 && $urandom_range(0, 60) == 0) go = 1'b1;
               cyc_in(k, $urandom_range(0, sp - 1) == 0, go, $urandom_range(0, 999) == 0);
               c++;
            end
         end
      end
      cyc_in(4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
